// File: rtl/data_receiver_fsm_pkg.sv
// Shared types and constants for the data receiver control FSM.
//   data_receiver_states_t : IDLE / LISTEN / ACK state encoding
//   LINK_TIMEOUT_CYCLES    : default watchdog limit (cycles without a good frame)
package data_receiver_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LISTEN = 2'd1,
    ACK    = 2'd2
  } data_receiver_states_t;

  localparam int LINK_TIMEOUT_CYCLES = 1_000_000;

endpackage

// File: rtl/data_receiver_fsm_link_watchdog.sv
// link_watchdog: saturating cycle counter that flags a dead link.
//   clk, rst_l : clock, async active-low reset
//   clear      : zero the counter (priority over en)
//   en         : count this cycle (saturates at LINK_TIMEOUT)
//   expired    : counter has reached LINK_TIMEOUT (registered-state decode)
module link_watchdog #(
  parameter int LINK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_l,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(LINK_TIMEOUT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l)                      cnt_q <= '0;
    else if (clear)                  cnt_q <= '0;
    else if (en && cnt_q != LIMIT)   cnt_q <= cnt_q + 1'b1;
  end

  assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/data_receiver_fsm.sv
// data_receiver_fsm: far-end control FSM for the serial data receivers.
// Accepts frames, drops corrupted ones (counting them), filters duplicates
// with an alternating sequence bit, pulses data_update for new payloads and
// kicks the ACK sender. A watchdog raises link_lost when no good frame has
// arrived for LINK_TIMEOUT cycles outside IDLE.
// Optional feature macro: DATA_RECV_SEQ_CHECK_EN (duplicate filtering). When
// undefined, every good frame pulses data_update.
// Ports:
//   clk, rst_l          : clock, async active-low reset
//   game_active         : game in progress; low forces IDLE
//   recv_done/err/seq   : frame finished / frame check failed / frame seq bit
//   ack_done            : ACK sender finished
//   recv_en             : enable serial receivers (LISTEN)
//   data_update         : 1-cycle pulse, latch remote payload
//   ack_start, ack_seq  : 1-cycle ACK launch pulse and the seq bit it carries
//   link_lost           : watchdog expired
//   err_cnt             : saturating bad-frame count
module data_receiver_fsm
  import data_receiver_fsm_pkg::*;
#(
  parameter int LINK_TIMEOUT = LINK_TIMEOUT_CYCLES,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 game_active,
  input  logic                 recv_done,
  input  logic                 recv_err,
  input  logic                 recv_seq,
  input  logic                 ack_done,
  output logic                 recv_en,
  output logic                 data_update,
  output logic                 ack_start,
  output logic                 ack_seq,
  output logic                 link_lost,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  data_receiver_states_t state_q, state_d;
  logic                  ack_seq_q, ack_seq_d;
  logic                  ack_start_q, ack_start_d;
  logic                  data_update_q, data_update_d;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  good_frame;
`ifdef DATA_RECV_SEQ_CHECK_EN
  logic                  exp_seq_q, exp_seq_d;
`endif

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= IDLE;
      ack_seq_q     <= 1'b0;
      ack_start_q   <= 1'b0;
      data_update_q <= 1'b0;
      err_cnt_q     <= '0;
`ifdef DATA_RECV_SEQ_CHECK_EN
      exp_seq_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ack_seq_q     <= ack_seq_d;
      ack_start_q   <= ack_start_d;
      data_update_q <= data_update_d;
      err_cnt_q     <= err_cnt_d;
`ifdef DATA_RECV_SEQ_CHECK_EN
      exp_seq_q     <= exp_seq_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    ack_seq_d     = ack_seq_q;
    ack_start_d   = 1'b0;
    data_update_d = 1'b0;
    err_cnt_d     = err_cnt_q;
    good_frame    = 1'b0;
`ifdef DATA_RECV_SEQ_CHECK_EN
    exp_seq_d     = exp_seq_q;
    if (state_q == IDLE) exp_seq_d = 1'b0;
`endif
    if (!game_active) begin
      // Any frame arriving alongside game end is discarded; ack_seq is kept.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   state_d = LISTEN;
        LISTEN: begin
          if (recv_done) begin
            if (recv_err) begin
              // No ACK: the remote sender times out and resends.
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
            end else begin
              good_frame  = 1'b1;
              ack_seq_d   = recv_seq;
              ack_start_d = 1'b1;
              state_d     = ACK;
`ifdef DATA_RECV_SEQ_CHECK_EN
              // Mismatch means our previous ACK was lost: re-ACK, no update.
              if (recv_seq == exp_seq_q) begin
                data_update_d = 1'b1;
                exp_seq_d     = ~exp_seq_q;
              end
`else
              data_update_d = 1'b1;
`endif
            end
          end
        end
        ACK:     if (ack_done) state_d = LISTEN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Clearing on !game_active as well makes link_lost read 0 in the first IDLE cycle.
  link_watchdog #(.LINK_TIMEOUT(LINK_TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_l   (rst_l),
    .clear   (!game_active || state_q == IDLE || good_frame),
    .en      (state_q == LISTEN || state_q == ACK),
    .expired (link_lost)
  );

  assign recv_en     = (state_q == LISTEN);
  assign ack_start   = ack_start_q;
  assign data_update = data_update_q;
  assign ack_seq     = ack_seq_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_data_receiver_fsm.sv
// Directed-vector bench for data_receiver_fsm (LINK_TIMEOUT=16, ERR_CNT_W=2).
module tb_data_receiver_fsm;

  logic       clk = 1'b0;
  logic       rst_l;
  logic       game_active, recv_done, recv_err, recv_seq, ack_done;
  logic       recv_en, data_update, ack_start, ack_seq, link_lost;
  logic [1:0] err_cnt;

  int n_vec = 0;
  int n_err = 0;

`ifdef DATA_RECV_SEQ_CHECK_EN
  localparam logic DUP_UPD = 1'b0;
`else
  localparam logic DUP_UPD = 1'b1;
`endif

  data_receiver_fsm #(.LINK_TIMEOUT(16), .ERR_CNT_W(2)) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .game_active (game_active),
    .recv_done   (recv_done),
    .recv_err    (recv_err),
    .recv_seq    (recv_seq),
    .ack_done    (ack_done),
    .recv_en     (recv_en),
    .data_update (data_update),
    .ack_start   (ack_start),
    .ack_seq     (ack_seq),
    .link_lost   (link_lost),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle frame pulse; on return outputs reflect the cycle after the frame.
  task automatic frame(input logic err, input logic seq);
    recv_done = 1'b1; recv_err = err; recv_seq = seq;
    tick();
    recv_done = 1'b0; recv_err = 1'b0;
  endtask

  task automatic finish_ack(input string tag);
    ack_done = 1'b1;
    tick();
    ack_done = 1'b0;
    check({tag, "_recv_en"}, recv_en, 1'b1);
  endtask

  initial begin
    rst_l = 1'b0; game_active = 1'b0; recv_done = 1'b0;
    recv_err = 1'b0; recv_seq = 1'b0; ack_done = 1'b0;
    #12;
    check("rst_recv_en",  recv_en, 1'b0);
    check("rst_ack_start", ack_start, 1'b0);
    check("rst_data_upd", data_update, 1'b0);
    check("rst_ack_seq",  ack_seq, 1'b0);
    check("rst_link_lost", link_lost, 1'b0);
    check("rst_err_cnt",  err_cnt, 2'd0);
    rst_l = 1'b1;
    tick();
    game_active = 1'b1;
    tick();
    check("listen_recv_en", recv_en, 1'b1);

    // New frame seq=0
    frame(1'b0, 1'b0);
    check("f0_ack_start", ack_start, 1'b1);
    check("f0_data_upd", data_update, 1'b1);
    check("f0_ack_seq", ack_seq, 1'b0);
    check("f0_recv_en", recv_en, 1'b0);
    tick();
    check("f0_ack_start_drop", ack_start, 1'b0);
    check("f0_data_upd_drop", data_update, 1'b0);
    // recv_done while in ACK is ignored
    frame(1'b0, 1'b1);
    check("inack_ack_start", ack_start, 1'b0);
    check("inack_data_upd", data_update, 1'b0);
    check("inack_ack_seq", ack_seq, 1'b0);
    check("inack_recv_en", recv_en, 1'b0);
    finish_ack("f0");

    // Duplicate seq=0, then new seq=1
    frame(1'b0, 1'b0);
    check("dup_ack_start", ack_start, 1'b1);
    check("dup_ack_seq", ack_seq, 1'b0);
    check("dup_data_upd", data_update, DUP_UPD);
    finish_ack("dup");
    frame(1'b0, 1'b1);
    check("f1_ack_start", ack_start, 1'b1);
    check("f1_data_upd", data_update, 1'b1);
    check("f1_ack_seq", ack_seq, 1'b1);
    finish_ack("f1");

    // Corrupted frames: counted, saturating, never ACKed
    for (int i = 0; i < 4; i++) begin
      frame(1'b1, 1'b0);
      check($sformatf("err%0d_ack_start", i), ack_start, 1'b0);
      check($sformatf("err%0d_recv_en", i), recv_en, 1'b1);
      check($sformatf("err%0d_cnt", i), err_cnt, (i < 3) ? i + 1 : 3);
    end

    // Frame coincident with game end is discarded
    game_active = 1'b0;
    frame(1'b0, 1'b0);
    check("drop_ack_start", ack_start, 1'b0);
    check("drop_data_upd", data_update, 1'b0);
    check("drop_recv_en", recv_en, 1'b0);
    check("drop_err_cnt", err_cnt, 2'd3);
    game_active = 1'b1;
    tick();   // IDLE -> LISTEN, watchdog held at 0
    check("wd_start_recv_en", recv_en, 1'b1);
    for (int i = 0; i < 15; i++) tick();
    check("wd_15_link_lost", link_lost, 1'b0);
    tick();
    check("wd_16_link_lost", link_lost, 1'b1);
    tick();
    check("wd_sat_link_lost", link_lost, 1'b1);
    // expected_seq was reset in IDLE, so seq=0 is new
    frame(1'b0, 1'b0);
    check("wd_clr_link_lost", link_lost, 1'b0);
    check("wd_clr_data_upd", data_update, 1'b1);
    finish_ack("wd");

    // Game ends mid-ACK: abandon, keep ack_seq
    frame(1'b0, 1'b1);
    check("ab_ack_seq", ack_seq, 1'b1);
    check("ab_data_upd", data_update, 1'b1);
    game_active = 1'b0;
    tick();
    check("ab_recv_en", recv_en, 1'b0);
    check("ab_link_lost", link_lost, 1'b0);
    check("ab_ack_start", ack_start, 1'b0);
    check("ab_ack_seq_kept", ack_seq, 1'b1);
    game_active = 1'b1;
    tick();
    check("re_recv_en", recv_en, 1'b1);
    frame(1'b0, 1'b0);
    check("re_data_upd", data_update, 1'b1);
    check("re_ack_start", ack_start, 1'b1);
    check("re_ack_seq", ack_seq, 1'b0);
    finish_ack("re");
    // Another seq=0: duplicate when filtering, new otherwise
    frame(1'b0, 1'b0);
    check("re_dup_data_upd", data_update, DUP_UPD);
    check("re_dup_ack_start", ack_start, 1'b1);
    finish_ack("re_dup");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
